gpu_cmd_scheduler: RTL and testbench
====================================

Name: gpu_cmd_scheduler

Overview:
- Shares the single GPU command port between two requesters: the CPU (`cpu_*`) and the system sequencer (`sys_*`, boot clear and debug).
- Buffers accepted commands in a small FIFO.
- Issues commands to the GPU one at a time using the GPU's submit/ready handshake.
- Reports idle to the CPU so draw instructions can stall until the display work completes.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- cpu_cmd  in  16  CPU GPU command
- cpu_valid  in  1  CPU request
- cpu_ready  out  1  CPU command accepted this cycle
- sys_cmd  in  16  system GPU command
- sys_valid  in  1  system request
- sys_ready  out  1  system command accepted this cycle
- gpu_cmd  out  16  command to GPU, registered
- gpu_cmd_submitted  out  1  one-cycle submit pulse, registered
- gpu_ready  in  1  GPU idle, waiting for a command
- sched_idle  out  1  FIFO empty and FSM in S_IDLE
- fifo_count  out  AW+1  occupancy, 0..DEPTH

Behaviour:
- Interface (already decided): one clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values:
  - gpu_cmd=16'h0000, gpu_cmd_submitted=0.
  - FIFO empty, fifo_count=0, pointers=0.
  - FSM=S_IDLE, rr_last=0 (CPU treated as last granted, so sys wins the first tie).
  - sched_idle=1.
- Reset asserted mid-operation:
  - Discards all queued commands and any in-flight tracking.
  - No submit pulse is generated in the cycle following reset.
- Arbitration (combinational readies):
  - At most one enqueue per cycle; nothing is granted while the FIFO is full.
  - Only sys_valid: sys_ready=1. Only cpu_valid: cpu_ready=1.
  - Both valid: round-robin; the requester not granted last time wins.
  - rr_last updates only on an actual grant.
  - Handshake is valid&ready. A requester holds its command and valid until it sees ready.
  - Readies are never asserted without the matching valid.
- FIFO:
  - Push on grant; pop on issue.
  - Simultaneous push and pop are allowed in any state, including full: when full, the pop frees a slot and the push is granted the same cycle.
  - fifo_count: +1 on push only, −1 on pop only, unchanged on both.
  - Pointers wrap modulo DEPTH.
- FSM:
  - S_IDLE: if FIFO not empty and gpu_ready=1, then:
    - register gpu_cmd<=head and gpu_cmd_submitted<=1;
    - pop;
    - go to S_ACCEPT.
  - S_ACCEPT: gpu_cmd_submitted<=0.
    - gpu_ready=0: go to S_BUSY.
    - gpu_ready still 1: remain, wait.
  - S_BUSY: gpu_ready=1 means the command finished; go to S_IDLE.
  - gpu_cmd holds the last issued value until the next issue.
  - Submit pulse width is exactly one cycle.
- Latency and throughput:
  - Command accepted at cycle N into an empty FIFO, FSM in S_IDLE, gpu_ready=1: gpu_cmd_submitted is high in cycle N+2.
  - The FIFO head is never popped while the FSM is outside S_IDLE.
  - Minimum spacing between submit pulses is 3 cycles plus the GPU busy time.
- sched_idle = (fifo_count==0) && (state==S_IDLE). It is combinational from registered state.

Test Plan:
- Reset then single issue:
  - Stimulus: rst high 2 cycles, then cpu_cmd=16'h00E0 with cpu_valid for one accepted cycle; model GPU drops ready the cycle after submit, stays busy 5 cycles.
  - Required: cpu_ready=1 at N; gpu_cmd=00E0 with gpu_cmd_submitted=1 at N+2 only.
  - Required: sched_idle=0 from N+1 until GPU ready returns, then 1.
- Round-robin tie:
  - Stimulus: both requesters valid continuously, sys_cmd=16'hD125, cpu_cmd=16'hD347, GPU held not ready.
  - Required: grants alternate sys, cpu, sys, cpu; 4 accepted; fifo_count=4; both readies 0 afterwards.
- Full with simultaneous pop:
  - Stimulus: fill FIFO to 4, then raise gpu_ready with cpu_valid high.
  - Required: in the issue cycle the pop and push coincide; cpu_ready=1; fifo_count stays 4.
- Order preservation:
  - Stimulus: enqueue 16'h0001, 0002, 0003, 0004; GPU responds normally.
  - Required: submits occur in that order; each pulse is exactly 1 cycle; no issue occurs while gpu_ready=0.
- Slow acceptance:
  - Stimulus: GPU keeps gpu_ready=1 for 3 cycles after a submit, then drops it.
  - Required: FSM stays in S_ACCEPT; no second pulse until ready falls and rises again.
- Reset mid-busy:
  - Stimulus: rst asserted with 3 queued and the FSM in S_BUSY.
  - Required: next cycle fifo_count=0, sched_idle=1, gpu_cmd_submitted=0, gpu_cmd=0000; no submit pulse until a new command is accepted.

Source files
------------

// File: rtl/gpu_cmd_scheduler.sv
// rtl/gpu_cmd_scheduler.sv - two-requester GPU command arbiter with FIFO and submit FSM
module gpu_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   cpu_cmd,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [15:0]   sys_cmd,
  input  logic          sys_valid,
  output logic          sys_ready,
  output logic [15:0]   gpu_cmd,
  output logic          gpu_cmd_submitted,
  input  logic          gpu_ready,
  output logic          sched_idle,
  output logic [AW:0]   fifo_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_BUSY   = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rr_last;     // 1: sys was granted last, 0: cpu was granted last
  logic          fifo_empty;
  logic          fifo_full;
  logic          issue;
  logic          push;
  logic [15:0]   push_data;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign push       = sys_ready | cpu_ready;
  assign push_data  = sys_ready ? sys_cmd : cpu_cmd;
  assign sched_idle = fifo_empty && (state == S_IDLE);

  // Round-robin grant; a pop in the same cycle frees a slot for a full FIFO
  always_comb begin
    sys_ready = 1'b0;
    cpu_ready = 1'b0;
    if (!fifo_full || issue) begin
      if (sys_valid && (!cpu_valid || !rr_last)) begin
        sys_ready = 1'b1;
      end else if (cpu_valid) begin
        cpu_ready = 1'b1;
      end
    end
  end

  // Remember which requester won the most recent actual grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b0;
    end else if (sys_ready) begin
      rr_last <= 1'b1;
    end else if (cpu_ready) begin
      rr_last <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !issue) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && issue) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: issue from idle, wait for GPU to take it, wait for GPU to finish
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && gpu_ready) begin
          issue      = 1'b1;
          state_next = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (!gpu_ready) begin
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (gpu_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Registered GPU command and one-cycle submit pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      gpu_cmd           <= 16'h0000;
      gpu_cmd_submitted <= 1'b0;
    end else begin
      gpu_cmd_submitted <= issue;
      if (issue) begin
        gpu_cmd <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// tb/tb_gpu_cmd_scheduler.sv - self-checking bench for gpu_cmd_scheduler
module tb_gpu_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst;
  logic [15:0]   cpu_cmd;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [15:0]   sys_cmd;
  logic          sys_valid;
  logic          sys_ready;
  logic [15:0]   gpu_cmd;
  logic          gpu_cmd_submitted;
  logic          gpu_ready;
  logic          sched_idle;
  logic [AW:0]   fifo_count;

  gpu_cmd_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_cmd           (cpu_cmd),
    .cpu_valid         (cpu_valid),
    .cpu_ready         (cpu_ready),
    .sys_cmd           (sys_cmd),
    .sys_valid         (sys_valid),
    .sys_ready         (sys_ready),
    .gpu_cmd           (gpu_cmd),
    .gpu_cmd_submitted (gpu_cmd_submitted),
    .gpu_ready         (gpu_ready),
    .sched_idle        (sched_idle),
    .fifo_count        (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // requester queues, GPU behaviour knobs, observation logs
  logic [15:0] cpu_q[$];
  logic [15:0] sys_q[$];
  logic        cpu_fire = 1'b0;
  logic        sys_fire = 1'b0;
  logic        gpu_auto = 1'b1;
  logic        gpu_manual = 1'b1;
  int          accept_delay = 0;
  int          busy_len = 5;
  logic [15:0] sub_log[$];
  int          sub_cyc[$];

  // reference model state
  logic [15:0] mq[$];
  int          gpu_phase = 0;  // 0 nothing outstanding, 1 submitted not yet taken, 2 GPU working
  logic        rr_sys_last = 1'b0;
  logic [15:0] e_cmd = 16'h0000;
  logic        e_sub = 1'b0;
  logic        model_ok = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sched_idle === 1'b1 && cpu_q.size() == 0 && sys_q.size() == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(sched_idle), 16'd1);
  endtask

  // capture handshakes for the requester drivers
  initial begin
    forever begin
      @(negedge clk);
      cpu_fire = cpu_valid && cpu_ready;
      sys_fire = sys_valid && sys_ready;
    end
  end

  // requester drivers: present queue head until accepted
  initial begin
    cpu_valid = 1'b0;
    sys_valid = 1'b0;
    cpu_cmd   = 16'h0000;
    sys_cmd   = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (cpu_fire && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (sys_fire && sys_q.size() > 0) void'(sys_q.pop_front());
      if (cpu_q.size() > 0) begin
        cpu_valid = 1'b1;
        cpu_cmd   = cpu_q[0];
      end else begin
        cpu_valid = 1'b0;
      end
      if (sys_q.size() > 0) begin
        sys_valid = 1'b1;
        sys_cmd   = sys_q[0];
      end else begin
        sys_valid = 1'b0;
      end
    end
  end

  // GPU responder: keeps ready for accept_delay cycles after a submit, then busy for busy_len
  initial begin
    int   hold_left;
    int   busy_left;
    logic auto_rdy;
    hold_left = 0;
    busy_left = 0;
    auto_rdy  = 1'b1;
    gpu_ready = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      if (gpu_cmd_submitted === 1'b1) begin
        hold_left = accept_delay;
        busy_left = busy_len;
        auto_rdy  = 1'b1;
      end else if (hold_left > 0) begin
        hold_left--;
        auto_rdy = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        auto_rdy = 1'b0;
      end else begin
        auto_rdy = 1'b1;
      end
      gpu_ready = gpu_auto ? auto_rdy : gpu_manual;
    end
  end

  // compare process: check DUT against the model every cycle, then advance the model
  initial begin
    logic issue_e;
    logic room;
    logic sys_e;
    logic cpu_e;
    forever begin
      @(negedge clk);
      cyc++;
      issue_e = 1'b0;
      sys_e   = 1'b0;
      cpu_e   = 1'b0;
      if (model_ok) begin
        issue_e = (gpu_phase == 0) && (mq.size() != 0) && gpu_ready;
        room    = (mq.size() < DEPTH) || issue_e;
        sys_e   = room && sys_valid && (!cpu_valid || !rr_sys_last);
        cpu_e   = room && cpu_valid && !sys_e;
        check("sys_ready", 16'(sys_ready), 16'(sys_e));
        check("cpu_ready", 16'(cpu_ready), 16'(cpu_e));
        check("fifo_count", 16'(fifo_count), 16'(mq.size()));
        check("sched_idle", 16'(sched_idle), 16'((mq.size() == 0) && (gpu_phase == 0)));
        check("gpu_cmd", gpu_cmd, e_cmd);
        check("gpu_cmd_submitted", 16'(gpu_cmd_submitted), 16'(e_sub));
      end
      if (gpu_cmd_submitted === 1'b1) begin
        sub_log.push_back(gpu_cmd);
        sub_cyc.push_back(cyc);
      end
      if (rst) begin
        mq.delete();
        gpu_phase   = 0;
        rr_sys_last = 1'b0;
        e_cmd       = 16'h0000;
        e_sub       = 1'b0;
        model_ok    = 1'b1;
      end else if (model_ok) begin
        e_sub = issue_e;
        if (issue_e) begin
          e_cmd     = mq.pop_front();
          gpu_phase = 1;
        end else if (gpu_phase == 1 && !gpu_ready) begin
          gpu_phase = 2;
        end else if (gpu_phase == 2 && gpu_ready) begin
          gpu_phase = 0;
        end
        if (sys_e) begin
          mq.push_back(sys_cmd);
          rr_sys_last = 1'b1;
        end else if (cpu_e) begin
          mq.push_back(cpu_cmd);
          rr_sys_last = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  // directed scenarios, then randomized traffic
  initial begin
    int n;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_gpu_cmd", gpu_cmd, 16'h0000);
    check("rst_submitted", 16'(gpu_cmd_submitted), 16'd0);
    check("rst_fifo_count", 16'(fifo_count), 16'd0);
    check("rst_sched_idle", 16'(sched_idle), 16'd1);

    // single issue, GPU busy 5 cycles after taking the command
    step();
    cpu_q.push_back(16'h00E0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) check("t1_cpu_ready", 16'(cpu_ready), 16'd1);
      check("t1_submit", 16'(gpu_cmd_submitted), 16'(k == 2));
      check("t1_idle", 16'(sched_idle), 16'(k == 0 || k == 9));
      if (k >= 2) check("t1_gpu_cmd", gpu_cmd, 16'h00E0);
      if (k < 9) step();
    end

    // round-robin tie with GPU held not ready
    step();
    gpu_auto   = 1'b0;
    gpu_manual = 1'b0;
    step();
    sys_q.push_back(16'hD125);
    sys_q.push_back(16'hD125);
    for (int k = 0; k < 3; k++) cpu_q.push_back(16'hD347);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_sys_ready", 16'(sys_ready), 16'(k == 0 || k == 2));
      check("t2_cpu_ready", 16'(cpu_ready), 16'(k == 1 || k == 3));
      if (k >= 4) check("t2_fifo_count", 16'(fifo_count), 16'd4);
      if (k < 5) step();
    end

    // full FIFO: issue pop and cpu push coincide
    step();
    accept_delay = 0;
    busy_len     = 2;
    gpu_auto     = 1'b1;
    @(negedge clk);
    check("t3_cpu_ready", 16'(cpu_ready), 16'd1);
    check("t3_count_issue", 16'(fifo_count), 16'd4);
    step();
    @(negedge clk);
    check("t3_count_after", 16'(fifo_count), 16'd4);
    check("t3_submit", 16'(gpu_cmd_submitted), 16'd1);
    check("t3_gpu_cmd", gpu_cmd, 16'hD125);
    wait_idle("t3_drain", 300);

    // order preservation
    step();
    sub_log.delete();
    sub_cyc.delete();
    for (int k = 1; k <= 4; k++) cpu_q.push_back(16'(k));
    wait_idle("t4_drain", 300);
    check("t4_count", 16'(sub_log.size()), 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < sub_log.size()) check("t4_order", sub_log[k], 16'(k + 1));
    end

    // slow acceptance: ready held 3 cycles after submit
    step();
    accept_delay = 3;
    busy_len     = 2;
    sub_log.delete();
    sub_cyc.delete();
    cpu_q.push_back(16'h0A0A);
    cpu_q.push_back(16'h0B0B);
    wait_idle("t5_drain", 300);
    check("t5_count", 16'(sub_cyc.size()), 16'd2);
    if (sub_cyc.size() == 2) begin
      check("t5_spacing", 16'(sub_cyc[1] - sub_cyc[0]), 16'd8);
      check("t5_second_cmd", sub_log[1], 16'h0B0B);
    end

    // reset while busy with 3 queued
    step();
    accept_delay = 0;
    busy_len     = 10;
    sub_log.delete();
    for (int k = 1; k <= 4; k++) cpu_q.push_back(16'h0600 + 16'(k));
    n = 0;
    @(negedge clk);
    while (!(fifo_count == 3 && gpu_ready == 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_pre_count", 16'(fifo_count), 16'd3);
    step();
    rst = 1'b1;
    cpu_q.delete();
    sys_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_count", 16'(fifo_count), 16'd0);
    check("t6_idle", 16'(sched_idle), 16'd1);
    check("t6_submit", 16'(gpu_cmd_submitted), 16'd0);
    check("t6_gpu_cmd", gpu_cmd, 16'h0000);
    repeat (12) @(negedge clk);
    check("t6_no_pulse", 16'(sub_log.size()), 16'd1);
    wait_idle("t6_drain", 100);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        cpu_q.delete();
        sys_q.delete();
        step();
        rst = 1'b0;
      end
      if (cpu_q.size() < 2 && $urandom_range(0, 2) == 0) cpu_q.push_back(16'($urandom));
      if (sys_q.size() < 2 && $urandom_range(0, 2) == 0) sys_q.push_back(16'($urandom));
      accept_delay = $urandom_range(0, 3);
      busy_len     = $urandom_range(1, 5);
      if ($urandom_range(0, 49) == 0) gpu_auto = !gpu_auto;
      gpu_manual = 1'($urandom_range(0, 1));
    end

    // drain with an alternating GPU ready so the FSM always progresses
    gpu_auto = 1'b0;
    n = 0;
    while (!(sched_idle === 1'b1 && cpu_q.size() == 0 && sys_q.size() == 0) && n < 400) begin
      step();
      gpu_manual = !gpu_manual;
      n++;
    end
    @(negedge clk);
    check("final_idle", 16'(sched_idle), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
